// File: rtl/bus_pkg.sv
// Shared bus definitions: funct3 access encodings, arbiter FSM states and
// byte-enable patterns. The core LSU imports the same package.
package bus_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_B    = 4'b0001;
  localparam logic [3:0] BE_H_LO = 4'b0011;
  localparam logic [3:0] BE_H_HI = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// Simple single-slave bus: registered command from the arbiter, ack and read
// data back from the slave.
interface bus_arbiter_rr_if #(
  parameter int XLEN = 32
) ();

  logic            req;
  logic            wr_en;
  logic [XLEN-1:0] addr;
  logic [XLEN-1:0] wr_data;
  logic [3:0]      byte_en;
  logic            ack;
  logic [XLEN-1:0] rd_data;

  modport master (
    output req, wr_en, addr, wr_data, byte_en,
    input  ack, rd_data
  );

  modport slave (
    input  req, wr_en, addr, wr_data, byte_en,
    output ack, rd_data
  );

endinterface

// File: rtl/bus_rr_arbiter.sv
// Combinational round-robin pick: first requester found scanning upward from
// the port after last_grant, wrapping at N_PORTS.
module bus_rr_arbiter #(
  parameter  int N_PORTS = 2,
  localparam int IDX_W   = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               valid
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate down so the nearest one is written last
  // and wins, which avoids a separate found flag.
  // NOTE: every output of this always_comb gets a default first; a path that
  // left one unassigned would infer a latch.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    cand  = '0;
    for (int k = N_PORTS; k >= 1; k--) begin
      cand = IDX_W'((int'(last_grant) + k) % N_PORTS);
      if (req[cand]) begin
        grant = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter of N requester ports onto the simple bus, with store
// alignment, load extension, misalignment errors and an optional ack timeout.
module bus_arbiter_rr
  import bus_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [N_PORTS-1:0]      i_req,
  input  logic [N_PORTS-1:0]      i_wen,
  input  logic [N_PORTS*XLEN-1:0] i_addr,
  input  logic [N_PORTS*XLEN-1:0] i_wdata,
  input  logic [N_PORTS*3-1:0]    i_f3,
  output logic [N_PORTS-1:0]      o_ready,
  output logic [N_PORTS-1:0]      o_err,
  output logic [XLEN-1:0]         o_rdata,
  bus_arbiter_rr_if.master        bus
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] lo,
                                        input logic wen);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_BU:   ok = !wen;
      F3_H:    ok = !lo[0];
      F3_HU:   ok = !lo[0] && !wen;
      F3_W:    ok = (lo == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] byte_en_of(input logic [2:0] f3, input logic [1:0] lo);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = BE_B << lo;
      2'b01:   be = lo[1] ? BE_H_HI : BE_H_LO;
      default: be = BE_W;
    endcase
    return be;
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                  input logic [XLEN-1:0] raw);
    logic [XLEN-1:0] s;
    logic [XLEN-1:0] r;
    s = raw >> {lo, 3'b000};
    case (f3)
      F3_B:    r = {{(XLEN-8){s[7]}}, s[7:0]};
      F3_BU:   r = {{(XLEN-8){1'b0}}, s[7:0]};
      F3_H:    r = {{(XLEN-16){s[15]}}, s[15:0]};
      F3_HU:   r = {{(XLEN-16){1'b0}}, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  state_e           state, state_n;
  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] arb_grant;
  logic             arb_valid;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       cur_f3;
  logic [1:0]       cur_lo;
  logic [XLEN-1:0]  sel_addr, sel_wdata;
  logic [2:0]       sel_f3;
  logic             sel_wen;
  logic             legal;
  logic             timed_out;

  bus_rr_arbiter #(.N_PORTS(N_PORTS)) u_arb (
    .req        (i_req),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .valid      (arb_valid)
  );

  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_f3    = '0;
    sel_wen   = 1'b0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (arb_grant == IDX_W'(p)) begin
        sel_addr  = i_addr[p*XLEN +: XLEN];
        sel_wdata = i_wdata[p*XLEN +: XLEN];
        sel_f3    = i_f3[p*3 +: 3];
        sel_wen   = i_wen[p];
      end
    end
  end

  assign legal     = access_legal(sel_f3, sel_addr[1:0], sel_wen);
  // An ack in the same cycle the limit is reached still completes normally.
  assign timed_out = (TIMEOUT > 0) && (state == ST_BUSY) && !bus.ack
                     && (cnt == CNT_W'(TIMEOUT));
  assign bus.req   = (state == ST_BUSY);

  // last_grant doubles as the owner of the transaction in BUSY/ERR.
  always_comb begin
    state_n = state;
    o_ready = '0;
    o_err   = '0;
    o_rdata = '0;
    case (state)
      ST_IDLE: if (arb_valid) state_n = legal ? ST_BUSY : ST_ERR;
      ST_BUSY: begin
        if (bus.ack) begin
          o_ready[last_grant] = 1'b1;
          if (!bus.wr_en) o_rdata = load_extend(cur_f3, cur_lo, bus.rd_data);
          state_n = ST_IDLE;
        end else if (timed_out) begin
          o_err[last_grant] = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_ERR: begin
        o_err[last_grant] = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      last_grant  <= IDX_W'(N_PORTS - 1);
      cnt         <= '0;
      cur_f3      <= '0;
      cur_lo      <= '0;
      bus.wr_en   <= 1'b0;
      bus.addr    <= '0;
      bus.wr_data <= '0;
      bus.byte_en <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && arb_valid) begin
        last_grant <= arb_grant;
        if (legal) begin
          cnt         <= CNT_W'(1);
          cur_f3      <= sel_f3;
          cur_lo      <= sel_addr[1:0];
          bus.wr_en   <= sel_wen;
          bus.addr    <= {sel_addr[XLEN-1:2], 2'b00};
          bus.wr_data <= sel_wen ? (sel_wdata << {sel_addr[1:0], 3'b000}) : '0;
          bus.byte_en <= byte_en_of(sel_f3, sel_addr[1:0]);
        end
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus randomized traffic checked
// against a transaction-level model of arbitration, alignment and extension.
module tb_bus_arbiter_rr;

  localparam int N  = 3;
  localparam int TO = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, wen;
  logic [N*32-1:0] addr, wdata;
  logic [N*3-1:0]  f3;
  logic [N-1:0]    rdy, err;
  logic [31:0]     rdata;

  bus_arbiter_rr_if #(.XLEN(32)) bus ();

  bus_arbiter_rr #(.N_PORTS(N), .XLEN(32), .TIMEOUT(TO)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_wen   (wen),
    .i_addr  (addr),
    .i_wdata (wdata),
    .i_f3    (f3),
    .o_ready (rdy),
    .o_err   (err),
    .o_rdata (rdata),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Requester-side view: one pending access per port
  bit          pend  [N];
  bit          p_wen [N];
  logic [31:0] p_addr[N];
  logic [31:0] p_wd  [N];
  logic [2:0]  p_f3  [N];
  int          model_last;
  bit          late_ack;
  bit          use_forced;
  logic [31:0] forced_rd;

  // ---------------- reference model ----------------
  function automatic int model_pick();
    for (int k = 1; k <= N; k++) begin
      int p;
      p = (model_last + k) % N;
      if (pend[p]) return p;
    end
    return -1;
  endfunction

  function automatic bit m_legal(input logic [2:0] fn, input logic [31:0] a, input bit w);
    int unsigned al;
    al = a % 4;
    case (fn)
      3'd0:    return 1'b1;
      3'd4:    return !w;
      3'd1:    return (al % 2) == 0;
      3'd5:    return ((al % 2) == 0) && !w;
      3'd2:    return al == 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int m_size(input logic [2:0] fn);
    case (fn % 4)
      0:       return 1;
      1:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] fn, input logic [31:0] a);
    int v;
    v = ((1 << m_size(fn)) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] w, input logic [31:0] a);
    longint unsigned v;
    v = longint'(w) << (8 * (a % 4));
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_rdata(input logic [2:0] fn, input logic [31:0] a,
                                          input logic [31:0] rd);
    longint unsigned v, mask;
    int bits;
    bits = 8 * m_size(fn);
    v    = longint'(rd) >> (8 * (a % 4));
    mask = (64'd1 << bits) - 1;
    v    = v & mask;
    if (fn < 4 && bits < 32 && ((v >> (bits - 1)) & 1) == 1) v = v | ~mask;
    return v[31:0];
  endfunction

  function automatic int first_set(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive();
    for (int p = 0; p < N; p++) begin
      req[p]          = pend[p];
      wen[p]          = p_wen[p];
      addr[p*32 +: 32]  = p_addr[p];
      wdata[p*32 +: 32] = p_wd[p];
      f3[p*3 +: 3]      = p_f3[p];
    end
  endtask

  task automatic set_req(input int p, input logic [31:0] a, input logic [2:0] fn,
                         input bit w, input logic [31:0] d);
    pend[p] = 1'b1; p_addr[p] = a; p_f3[p] = fn; p_wen[p] = w; p_wd[p] = d;
  endtask

  task automatic new_requests(input int pct);
    logic [2:0]  f3_tab [8];
    logic [31:0] a;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd3, 3'd7};
    for (int p = 0; p < N; p++) begin
      if (!pend[p] && $urandom_range(0, 99) < pct) begin
        a = $urandom;
        if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
        set_req(p, a, f3_tab[$urandom_range(0, 7)], bit'($urandom_range(0, 1)), $urandom);
      end
    end
  endtask

  // One arbitration round: entered and left just after a rising edge with the
  // DUT idle. lat = BUSY cycle carrying the ack; lat > TO means no ack.
  task automatic round(input int lat, output int obs, output int cyc);
    int w;
    logic [N-1:0] oh;
    obs = -1;
    cyc = -1;
    drive();
    bus.ack     = late_ack;
    bus.rd_data = $urandom;
    @(negedge clk);
    check("idle_req",   bus.req, 1'b0);
    check("idle_ready", rdy, '0);
    check("idle_err",   err, '0);
    check("idle_rdata", rdata, '0);
    late_ack = 1'b0;
    w = model_pick();
    @(posedge clk); #1;
    if (w < 0) return;
    model_last = w;
    oh = '0;
    oh[w] = 1'b1;
    if (!m_legal(p_f3[w], p_addr[w], p_wen[w])) begin
      bus.ack = bit'($urandom_range(0, 1));
      @(negedge clk);
      check("err_pulse", err, oh);
      check("err_ready", rdy, '0);
      check("err_req",   bus.req, 1'b0);
      obs = first_set(err);
      cyc = cycle;
      @(posedge clk); #1;
      bus.ack = 1'b0;
      pend[w] = 1'b0;
      return;
    end
    for (int c = 1; c <= TO; c++) begin
      bus.ack     = (c == lat);
      bus.rd_data = use_forced ? forced_rd : $urandom;
      @(negedge clk);
      check("busy_req", bus.req, 1'b1);
      if (c == 1) begin
        check("cmd_addr", bus.addr, p_addr[w] & 32'hFFFF_FFFC);
        check("cmd_be",   bus.byte_en, m_be(p_f3[w], p_addr[w]));
        check("cmd_wen",  bus.wr_en, p_wen[w]);
        if (p_wen[w]) check("cmd_wdata", bus.wr_data, m_wdata(p_wd[w], p_addr[w]));
      end
      if (c == lat) begin
        check("ready", rdy, oh);
        check("ready_err", err, '0);
        check("rdata", rdata, p_wen[w] ? 32'd0 : m_rdata(p_f3[w], p_addr[w], bus.rd_data));
        obs = first_set(rdy);
        cyc = cycle;
      end else if (c == TO) begin
        check("timeout_err",   err, oh);
        check("timeout_ready", rdy, '0);
        check("timeout_rdata", rdata, '0);
        obs = first_set(err);
        cyc = cycle;
        late_ack = 1'b1;
      end else begin
        check("busy_ready", rdy, '0);
        check("busy_err",   err, '0);
      end
      @(posedge clk); #1;
      if (c == lat || c == TO) break;
    end
    bus.ack    = 1'b0;
    pend[w]    = 1'b0;
    use_forced = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int obs, cyc, prev_cyc;
    int alt_exp [4];
    alt_exp = '{0, 1, 0, 1};

    for (int p = 0; p < N; p++) set_req(p, 32'd0, 3'd0, 1'b0, 32'd0);
    for (int p = 0; p < N; p++) pend[p] = 1'b0;
    late_ack = 1'b0; use_forced = 1'b0; forced_rd = '0;
    rst = 1'b0; bus.ack = 1'b0; bus.rd_data = '0;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req",     bus.req, 1'b0);
    check("rst_addr",    bus.addr, '0);
    check("rst_wr_en",   bus.wr_en, 1'b0);
    check("rst_be",      bus.byte_en, '0);
    check("rst_ready",   rdy, '0);
    check("rst_err",     err, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    model_last = N - 1;

    // Byte read, sign-extended from the top lane
    set_req(1, 32'h0000_0103, 3'd0, 1'b0, 32'd0);
    use_forced = 1'b1;
    forced_rd  = 32'h80FF_FFFF;
    round(1, obs, cyc);
    check("lb_port", obs, 1);

    // Halfword store into the upper half
    set_req(1, 32'h0000_0102, 3'd1, 1'b1, 32'h1234_ABCD);
    round(2, obs, cyc);
    check("sh_port", obs, 1);

    // Two ports continuously requesting: strict alternation, 2 cycles apart
    prev_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p]) set_req(p, 32'h0000_1000 + 32'(16 * i), 3'd2, 1'b0, 32'd0);
      round(1, obs, cyc);
      check("alt_port", obs, alt_exp[i]);
      if (i > 0) check("alt_spacing", cyc - prev_cyc, 2);
      prev_cyc = cyc;
    end
    pend[0] = 1'b0;
    pend[1] = 1'b0;

    // Misaligned word read, then a normal request
    set_req(0, 32'h0000_2002, 3'd2, 1'b0, 32'd0);
    round(1, obs, cyc);
    check("misalign_port", obs, 0);
    set_req(1, 32'h0000_2000, 3'd2, 1'b0, 32'd0);
    round(1, obs, cyc);
    check("after_err_port", obs, 1);

    // Timeout, then a late ack in the following idle cycle
    set_req(2, 32'h0000_0055, 3'd0, 1'b0, 32'd0);
    round(TO + 1, obs, cyc);
    check("timeout_port", obs, 2);
    round(1, obs, cyc);

    // Reset in the middle of a transaction
    set_req(2, 32'h0000_0040, 3'd2, 1'b0, 32'd0);
    drive();
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_busy", bus.req, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    bus.ack     = 1'b1;
    bus.rd_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("midrst_req",   bus.req, 1'b0);
    check("midrst_addr",  bus.addr, '0);
    check("midrst_wdata", bus.wr_data, '0);
    check("midrst_be",    bus.byte_en, '0);
    check("midrst_wr_en", bus.wr_en, 1'b0);
    check("midrst_ready", rdy, '0);
    check("midrst_err",   err, '0);
    check("midrst_rdata", rdata, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.ack = 1'b0;
    model_last = N - 1;
    for (int p = 0; p < N; p++) set_req(p, 32'h0000_0300 + 32'(4 * p), 3'd2, 1'b0, 32'd0);
    round(1, obs, cyc);
    check("post_rst_port", obs, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      new_requests(45);
      round($urandom_range(1, TO + 1), obs, cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_rr.md
# bus_arbiter_rr

Parametrised successor to the single-core datapath-to-bus converter. It arbitrates N requester ports (I-fetch, D-port, and optionally a debug/DMA port) onto the single simple bus with round-robin fairness. It aligns store data and byte enables, and sign/zero-extends load data. It also flags misaligned accesses and bus timeouts as errors instead of hanging. It sits between the core's memory ports and the shared bus slave.

## Interface
- N_PORTS, 2, number of requester ports (1..8); port 0 is fetch by convention
- XLEN, 32, data/address width (only 32 supported for alignment logic)
- TIMEOUT, 0, max BUSY cycles awaiting i_ack; 0 disables timeout
- Clock/reset: reset i_rst, synchronous, active-low; clock i_clk.
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-low reset
- i_req  in  N_PORTS  per-port request; held high until o_ready or o_err of that port
- i_wen  in  N_PORTS  per-port write (1) / read (0)
- i_addr  in  N_PORTS*XLEN  per-port byte address, port p at [p*XLEN +: XLEN]
- i_wdata  in  N_PORTS*XLEN  per-port store data, LSB-justified
- i_f3  in  N_PORTS*3  per-port funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
- o_ready  out  N_PORTS  one-cycle completion pulse to the granted port
- o_err  out  N_PORTS  one-cycle error pulse (misaligned, bad f3, timeout)
- o_rdata  out  XLEN  aligned/extended load data; valid when o_ready of a read port is high, else 0
- o_req  out  1  bus transaction valid, high throughout BUSY
- o_wr_en, o_addr[XLEN], o_wr_data[XLEN], o_byte_en[4]  out  bus command, registered
- i_ack  in  1  bus completion; i_rd_data  in  XLEN  read data, sampled when i_ack is high

## Operation
- States: IDLE, BUSY, ERR.
- IDLE: if any i_req is high, grant the first requester found scanning from (last_grant+1) mod N_PORTS upward.
  - Legal access: register the command, go to BUSY, and update last_grant.
  - Illegal access: go to ERR and update last_grant. Illegal means H with addr[0]=1, W/BU-illegal combos with addr[1:0]≠0 for W, f3[1:0]=11, or a write with f3[2]=1.
- Command registration:
  - o_addr = {addr[31:2],2'b00} for both reads and writes.
  - o_byte_en: B → one-hot on addr[1:0]; H → 0011/1100 by addr[1]; W → 1111.
  - o_wr_data = wdata << (8*addr[1:0]) for writes.
- BUSY: o_req=1.
  - On i_ack: pulse o_ready[grant] combinationally in the same cycle. For reads, o_rdata = (i_rd_data >> 8*addr[1:0]), sign-extended for B/H and zero-extended for BU/HU. Go to IDLE.
  - With TIMEOUT>0, if the counter reaches TIMEOUT without i_ack: pulse o_err[grant], drop o_req, go to IDLE. A late i_ack is ignored.
- ERR: pulse o_err[grant] for one cycle with no bus activity, then go to IDLE.
- i_ack is ignored in IDLE and ERR.
- A port dropping i_req mid-BUSY is a protocol violation; the transaction still completes and the response goes to the original grant.

## Timing
- Reset (i_rst=0 at a clock edge, including mid-BUSY):
  - State goes to IDLE and last_grant to N_PORTS-1, so port 0 has first priority.
  - o_req, o_wr_en, o_addr, o_wr_data, o_byte_en, and the timeout counter are cleared.
  - o_ready, o_err, and o_rdata are 0.
- Request high at edge t in IDLE: command appears at t+1 with o_req=1. The earliest i_ack is at t+1, which gives o_ready at t+1. Minimum 2 cycles per transaction; the bus is idle one cycle between grants.
- Misaligned request: o_err is high in cycle t+1.
- Timeout: o_err is high in the cycle in which the counter equals TIMEOUT, counting from the first BUSY cycle = 1.
- With two ports continuously requesting, grants strictly alternate.

## Structure
- Package bus_pkg holds the f3 encodings (F3_B/H/W/BU/HU), the state encoding, and the byte-enable constants; these are shared with the core LSU.
- Sub-module bus_rr_arbiter (N_PORTS parameter; inputs req and last_grant; outputs grant index and valid) is purely combinational.
- Alignment and extension logic stays in the top module as functions.

## Test plan
- Single read on port 1: addr 0x103, f3=000, i_rd_data=0x80FF_FFFF → o_addr 0x100, o_byte_en 1000, o_rdata 0xFFFF_FF80.
- Halfword store on port 1: addr 0x0102, wdata 0x1234_ABCD → o_wr_data 0xABCD_0000, o_byte_en 1100, o_wr_en 1.
- Ports 0 and 1 both hold i_req with ack after 1 cycle → grants alternate 0,1,0,1. Each o_ready arrives 2 cycles apart, and neither port is starved.
- Word read at addr 0x2002 → o_err pulses for one cycle, o_req never rises, and the next request is served normally.
- TIMEOUT=4 with no i_ack → o_err[grant] in the 4th BUSY cycle and o_req drops; an i_ack one cycle later produces no o_ready.
- Reset asserted mid-BUSY → all outputs are 0 the next cycle, and after reset port 0 wins simultaneous requests.
